// File: rtl/sb_req_arbiter.sv
// sb_req_arbiter: round-robin arbiter that funnels per-FSM resource requests
// into the scoreboard's single registered request port. Memory-claiming
// opcodes wait for a free bank plus a short holdoff after each memory grant.
//
// Optional feature macro: SB_ARB_STARVE_EN (starvation-priority override).
//
// Handshake: requester i offers a request by raising req_valid[i] and holding
// req_opcode[i] steady; the request is accepted in the cycle where
// req_valid[i] && req_ready[i]. req_ready is combinational, at most one-hot,
// and never depends on the requester seeing its own ready first. Dropping
// req_valid before acceptance withdraws the request with no side effects.

package sb_common_pkg;
    localparam int unsigned MEM_OPCODE_READ       = 1;
    localparam int unsigned MEM_OPCODE_WRITE_ADDR = 2;
endpackage

module sb_req_arbiter
    import sb_common_pkg::*;
#(
    parameter int                            NUM_REQ      = 4,
    parameter int                            SRC_ID_W     = 4,
    parameter int                            OPCODE_W     = 2,
    parameter logic [NUM_REQ*SRC_ID_W-1:0]   REQ_SRC_IDS  = '0,
    parameter int                            MEM_HOLDOFF  = 1,
    parameter int                            STARVE_LIMIT = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*OPCODE_W-1:0]      req_opcode,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             mem_ready,
    output logic                             sb_req_valid,
    output logic [SRC_ID_W-1:0]              sb_req_src_id,
    output logic [OPCODE_W-1:0]              sb_req_opcode
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]    r_rr_ptr;
    logic [2:0]          r_holdoff_cnt;

    logic [NUM_REQ-1:0]  w_is_mem;
    logic [NUM_REQ-1:0]  w_eligible;
    logic                w_mem_open;
    logic                w_rr_found;
    logic [PTR_W-1:0]    w_rr_idx;
    logic                w_grant_any;
    logic [PTR_W-1:0]    w_grant_idx;
    logic                w_xfer;
    logic                w_xfer_mem;
    logic [SRC_ID_W-1:0] w_grant_src;
    logic [OPCODE_W-1:0] w_grant_op;

    // Classify each request and decide whether it may be granted this cycle.
    always_comb begin
        w_is_mem   = '0;
        w_eligible = '0;
        w_mem_open = mem_ready && (r_holdoff_cnt == 3'd0);
        for (int i = 0; i < NUM_REQ; i++) begin
            w_is_mem[i] = (req_opcode[i*OPCODE_W +: OPCODE_W] == OPCODE_W'(MEM_OPCODE_READ)) ||
                          (req_opcode[i*OPCODE_W +: OPCODE_W] == OPCODE_W'(MEM_OPCODE_WRITE_ADDR));
            w_eligible[i] = req_valid[i] && (!w_is_mem[i] || w_mem_open);
        end
    end

    // Round-robin search from rr_ptr+1: first eligible index above the pointer,
    // otherwise wrap to the lowest eligible index.
    always_comb begin
        logic            v_hi_found;
        logic [PTR_W-1:0] v_hi_idx;
        logic            v_lo_found;
        logic [PTR_W-1:0] v_lo_idx;
        v_hi_found = 1'b0;
        v_hi_idx   = '0;
        v_lo_found = 1'b0;
        v_lo_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_eligible[i] && !v_lo_found) begin
                v_lo_found = 1'b1;
                v_lo_idx   = PTR_W'(i);
            end
            if (w_eligible[i] && !v_hi_found && (i > int'(r_rr_ptr))) begin
                v_hi_found = 1'b1;
                v_hi_idx   = PTR_W'(i);
            end
        end
        w_rr_found = v_lo_found;
        w_rr_idx   = v_hi_found ? v_hi_idx : v_lo_idx;
    end

`ifdef SB_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]    r_wait_cnt [NUM_REQ];
    logic                w_st_found;
    logic [PTR_W-1:0]    w_st_idx;

    // A starved, eligible requester (lowest index first) overrides round-robin.
    always_comb begin
        w_st_found = 1'b0;
        w_st_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_eligible[i] && !w_st_found &&
                (r_wait_cnt[i] >= CNT_W'(STARVE_LIMIT))) begin
                w_st_found = 1'b1;
                w_st_idx   = PTR_W'(i);
            end
        end
        w_grant_any = w_rr_found;
        w_grant_idx = w_st_found ? w_st_idx : w_rr_idx;
    end

    // Saturating wait counters: count cycles spent valid but not accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || req_ready[i]) begin
                    r_wait_cnt[i] <= '0;
                end else if (r_wait_cnt[i] != {CNT_W{1'b1}}) begin
                    r_wait_cnt[i] <= r_wait_cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    // Pure round-robin grant selection.
    always_comb begin
        w_grant_any = w_rr_found;
        w_grant_idx = w_rr_idx;
    end
`endif

    // Drive the one-hot grant; nothing is granted while reset is asserted.
    always_comb begin
        req_ready   = '0;
        w_xfer      = 1'b0;
        w_xfer_mem  = 1'b0;
        w_grant_src = REQ_SRC_IDS[w_grant_idx*SRC_ID_W +: SRC_ID_W];
        w_grant_op  = req_opcode[w_grant_idx*OPCODE_W +: OPCODE_W];
        if (!rst && w_grant_any) begin
            req_ready  = NUM_REQ'(1) << w_grant_idx;
            w_xfer     = 1'b1;
            w_xfer_mem = w_is_mem[w_grant_idx];
        end
    end

    // Register the accepted request toward the scoreboard and advance rr_ptr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr      <= PTR_W'(NUM_REQ - 1);
            sb_req_valid  <= 1'b0;
            sb_req_src_id <= '0;
            sb_req_opcode <= '0;
        end else begin
            sb_req_valid <= w_xfer;
            if (w_xfer) begin
                r_rr_ptr      <= w_grant_idx;
                sb_req_src_id <= w_grant_src;
                sb_req_opcode <= w_grant_op;
            end
        end
    end

    // Memory holdoff: reload on a memory grant, otherwise count down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_holdoff_cnt <= 3'd0;
        end else if (w_xfer && w_xfer_mem) begin
            r_holdoff_cnt <= 3'(MEM_HOLDOFF);
        end else if (r_holdoff_cnt != 3'd0) begin
            r_holdoff_cnt <= r_holdoff_cnt - 3'd1;
        end
    end

endmodule
